// File: rtl/soc_test_monitor.sv
// soc_test_monitor
//   Supervises one test run of an SoC: enables instruction fetch, counts
//   run cycles, waits for the SoC to write a nonzero completion flag, and
//   compares the reported result word against a golden value. A run also
//   ends on a cycle-count timeout or when the fetch address stops moving
//   (stall).
//
// Parameters
//   TIMEOUT_CYCLES  RUN cycles before timeout is declared
//   STALL_CYCLES    consecutive unchanged fetch addresses that flag a stall
//   CNT_W           width of the RUN cycle counter
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   start_i         arms a run (accepted in IDLE or END)
//   expected_i      golden result, latched when start_i is accepted
//   mem_flag_i      SoC completion flag, nonzero = done
//   mem_result_i    SoC result word
//   instr_addr_i    SoC fetch address
//   fetch_enable_o  SoC fetch enable (high in RUN)
//   busy_o          high in RUN or CHECK
//   done_o          one-cycle pulse on the first END cycle
//   pass_o/fail_o/timeout_o/stall_o  sticky run status
//   result_o        captured mem_result_i
//   cycles_o        RUN cycle count, saturating
module soc_test_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned STALL_CYCLES   = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      expected_i,
  input  logic [31:0]      mem_flag_i,
  input  logic [31:0]      mem_result_i,
  input  logic [31:0]      instr_addr_i,
  output logic             fetch_enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic             stall_o,
  output logic [31:0]      result_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  localparam logic [CNT_W:0] TIMEOUT_W = (CNT_W+1)'(TIMEOUT_CYCLES);
  localparam logic [CNT_W:0] ONE_W     = (CNT_W+1)'(1);

  logic [1:0]       state;
  logic [31:0]      expected;
  logic [31:0]      prev_addr;
  logic [31:0]      stall_cnt;
  logic             primed;

  logic [CNT_W:0]   cycles_inc;
  logic [CNT_W-1:0] cycles_next;
  logic [31:0]      stall_next;
  logic             hit_timeout;
  logic             hit_stall;

  assign fetch_enable_o = (state == S_RUN);
  assign busy_o         = (state == S_RUN) || (state == S_CHECK);

  always_comb begin
    // One extra bit so the timeout compare still works when the count is all-ones.
    cycles_inc  = {1'b0, cycles_o} + ONE_W;
    cycles_next = (&cycles_o) ? cycles_o : cycles_inc[CNT_W-1:0];
    hit_timeout = (cycles_inc == TIMEOUT_W);
    // The first RUN cycle only loads prev_addr, so the counter stays at zero.
    stall_next  = '0;
    if (primed && (instr_addr_i == prev_addr)) begin
      stall_next = stall_cnt + 32'd1;
    end
    hit_stall   = (stall_next == STALL_CYCLES);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      expected  <= '0;
      prev_addr <= '0;
      stall_cnt <= '0;
      primed    <= 1'b0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
      stall_o   <= 1'b0;
      result_o  <= '0;
      cycles_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE, S_END: begin
          if (start_i) begin
            state     <= S_RUN;
            expected  <= expected_i;
            stall_cnt <= '0;
            primed    <= 1'b0;
            pass_o    <= 1'b0;
            fail_o    <= 1'b0;
            timeout_o <= 1'b0;
            stall_o   <= 1'b0;
            result_o  <= '0;
            cycles_o  <= '0;
          end
        end
        S_RUN: begin
          cycles_o  <= cycles_next;
          prev_addr <= instr_addr_i;
          primed    <= 1'b1;
          stall_cnt <= stall_next;
          // Completion beats timeout beats stall; only one cause is recorded.
          if (mem_flag_i != '0) begin
            result_o <= mem_result_i;
            state    <= S_CHECK;
          end else if (hit_timeout) begin
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            state     <= S_END;
          end else if (hit_stall) begin
            stall_o <= 1'b1;
            done_o  <= 1'b1;
            state   <= S_END;
          end
        end
        S_CHECK: begin
          pass_o <= (result_o == expected);
          fail_o <= (result_o != expected);
          done_o <= 1'b1;
          state  <= S_END;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
